// File: rtl/cozy_loader_pkg.sv
// Shared constants and state encoding for the cozy_cpu program loader.
package cozy_loader_pkg;

    localparam logic [7:0] LOADER_MAGIC = 8'hC0;
    localparam int         MEM_WORDS    = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DHI,
        ST_DLO,
        ST_CSUM,
        ST_RUN
    } state_t;

    function automatic logic len_ok(input logic [7:0] n);
        return (n != 8'd0) && (n <= 8'(MEM_WORDS));
    endfunction

endpackage

// File: rtl/cozy_loader_timer.sv
// Inter-byte watchdog: counts idle cycles while enabled, flags the last allowed cycle.
// Combinational expired from a registered count; clear has priority over counting.
module cozy_loader_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/cozy_loader.sv
// Receives a framed program image byte stream and writes 16-bit words into cozy_cpu RAM.
// Word write lands 1 clk after its lo byte; no backpressure, CPU held in reset until checksum verifies.
module cozy_loader
    import cozy_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_reset_n,
    output logic        busy,
    output logic        error,
    output logic        loaded
);

    state_t     state;
    logic [6:0] index;
    logic [7:0] len;
    logic [7:0] sum;
    logic [7:0] hi;
    logic       active;
    logic       expired;
    logic       is_magic;

    assign active   = state inside {ST_LEN, ST_DHI, ST_DLO, ST_CSUM};
    assign is_magic = rx_valid && (rx_data == LOADER_MAGIC);

    // Watchdog restarts on every byte and stays parked while no frame is open.
    cozy_loader_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (rx_valid | ~active),
        .enable (active),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            index       <= '0;
            len         <= '0;
            sum         <= '0;
            hi          <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            cpu_reset_n <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
            loaded      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (active && !rx_valid && expired) begin
                state <= ST_IDLE;
                error <= 1'b1;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_RUN: begin
                        if (is_magic) begin
                            state       <= ST_LEN;
                            busy        <= 1'b1;
                            error       <= 1'b0;
                            cpu_reset_n <= 1'b0;
                            loaded      <= 1'b0;
                        end
                    end
                    ST_LEN: begin
                        if (rx_valid) begin
                            if (len_ok(rx_data)) begin
                                state <= ST_DHI;
                                len   <= rx_data;
                                index <= '0;
                                sum   <= '0;
                            end else begin
                                state <= ST_IDLE;
                                error <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    ST_DHI: begin
                        if (rx_valid) begin
                            hi    <= rx_data;
                            sum   <= sum + rx_data;
                            state <= ST_DLO;
                        end
                    end
                    ST_DLO: begin
                        if (rx_valid) begin
                            sum       <= sum + rx_data;
                            mem_we    <= 1'b1;
                            mem_addr  <= {index, 1'b0};
                            mem_wdata <= {hi, rx_data};
                            if ({1'b0, index} == len - 8'd1) begin
                                state <= ST_CSUM;
                            end else begin
                                index <= index + 7'd1;
                                state <= ST_DHI;
                            end
                        end
                    end
                    ST_CSUM: begin
                        if (rx_valid) begin
                            busy <= 1'b0;
                            if (rx_data == sum) begin
                                state       <= ST_RUN;
                                cpu_reset_n <= 1'b1;
                                loaded      <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                                error <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cozy_loader.sv
// Self-checking bench for cozy_loader: vector table, corner-case sequences, randomized frames vs. a frame-level model.
module tb_cozy_loader;

    localparam int         TO    = 200;
    localparam logic [7:0] MAGIC = 8'hC0;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_reset_n;
    logic        busy;
    logic        error;
    logic        loaded;

    int checks   = 0;
    int failures = 0;

    logic [23:0] wq[$];

    always #5 clk = ~clk;

    cozy_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset_n(cpu_reset_n),
        .busy       (busy),
        .error      (error),
        .loaded     (loaded)
    );

    always @(negedge clk) begin
        if (mem_we === 1'b1) wq.push_back({mem_addr, mem_wdata});
    end

    typedef struct {
        string       name;
        logic [63:0] bytes;
        int          n;
        logic        err;
        logic        ld;
        int          nwr;
        logic [23:0] first_wr;
        logic [23:0] last_wr;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input string name, input logic [63:0] bytes, input int n,
                                input logic err, input logic ld, input int nwr,
                                input logic [23:0] first_wr, input logic [23:0] last_wr);
        vec_t v;
        v.name = name; v.bytes = bytes; v.n = n; v.err = err; v.ld = ld;
        v.nwr = nwr; v.first_wr = first_wr; v.last_wr = last_wr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        rx_valid = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    task automatic chk_status(input string tag, input logic err, input logic ld,
                              input logic rn, input logic bsy);
        chk({tag, "_error"},       32'(error),       32'(err));
        chk({tag, "_loaded"},      32'(loaded),      32'(ld));
        chk({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'(rn));
        chk({tag, "_busy"},        32'(busy),        32'(bsy));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_status(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  fb[$];
        logic [23:0] exp_wr[$];
        logic [7:0]  b, len, hi, lo, s;
        logic        exp_err;
        int          kind;

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset_held");
        reset = 1'b0;
        idle(1);
        chk_reset_vals("reset_released");

        vecs[0] = mk("good2",    64'hC002_1234_5678_1400, 7, 1'b0, 1'b1, 2, 24'h00_1234, 24'h02_5678);
        vecs[1] = mk("badcsum",  64'hC001_AABB_0000_0000, 5, 1'b1, 1'b0, 1, 24'h00_AABB, 24'h00_AABB);
        vecs[2] = mk("stray_id", 64'h1234_FF00_0000_0000, 3, 1'b1, 1'b0, 0, 24'h0, 24'h0);
        vecs[3] = mk("len00",    64'hC000_0000_0000_0000, 2, 1'b1, 1'b0, 0, 24'h0, 24'h0);
        vecs[4] = mk("len81",    64'hC081_0000_0000_0000, 2, 1'b1, 1'b0, 0, 24'h0, 24'h0);
        vecs[5] = mk("recover",  64'hC001_0001_0100_0000, 5, 1'b0, 1'b1, 1, 24'h00_0001, 24'h00_0001);
        vecs[6] = mk("reload",   64'hC001_0000_0000_0000, 5, 1'b0, 1'b1, 1, 24'h00_0000, 24'h00_0000);
        vecs[7] = mk("stray_run",64'h1200_FF00_0000_0000, 3, 1'b0, 1'b1, 0, 24'h0, 24'h0);

        for (int v = 0; v < 8; v++) begin
            wq.delete();
            for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].bytes[63-8*i -: 8]);
            idle(2);
            chk_status(vecs[v].name, vecs[v].err, vecs[v].ld, vecs[v].ld, 1'b0);
            chk({vecs[v].name, "_nwr"}, 32'(wq.size()), 32'(vecs[v].nwr));
            if (vecs[v].nwr > 0 && wq.size() > 0) begin
                chk({vecs[v].name, "_first_wr"}, 32'(wq[0]), 32'(vecs[v].first_wr));
                chk({vecs[v].name, "_last_wr"},  32'(wq[wq.size()-1]), 32'(vecs[v].last_wr));
            end
        end

        // Reload from RUN: CPU drops into reset on the MAGIC edge, released one clk after the checksum.
        send_byte(MAGIC);
        chk_status("reload_magic", 1'b0, 1'b0, 1'b0, 1'b1);
        send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        chk_status("reload_pre_csum", 1'b0, 1'b0, 1'b0, 1'b1);
        send_byte(8'h14);
        chk_status("reload_post_csum", 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Timeout after a hi byte.
        wq.delete();
        send_byte(MAGIC); send_byte(8'h01); send_byte(8'h12);
        idle(TO - 1);
        chk_status("to_before_expiry", 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk_status("to_expired", 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("to_nwr", 32'(wq.size()), 32'd0);

        // A byte landing in the expiry cycle is accepted.
        wq.delete();
        send_byte(MAGIC); send_byte(8'h01); send_byte(8'h12);
        idle(TO - 1);
        send_byte(8'h34);
        chk_status("to_edge_byte", 1'b0, 1'b0, 1'b0, 1'b1);
        send_byte(8'h46);
        idle(2);
        chk_status("to_edge_done", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("to_edge_nwr", 32'(wq.size()), 32'd1);
        if (wq.size() > 0) chk("to_edge_wr", 32'(wq[0]), 32'h00_1234);

        // Reset between hi and lo bytes, with a lo byte presented during reset.
        wq.delete();
        send_byte(MAGIC); send_byte(8'h01); send_byte(8'h12);
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h34;
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        chk_reset_vals("midreset");
        idle(2);
        chk("midreset_nwr", 32'(wq.size()), 32'd0);
        send_byte(8'h34); send_byte(8'h56); send_byte(8'h00);
        idle(1);
        chk_status("midreset_stray", 1'b0, 1'b0, 1'b0, 1'b0);
        send_byte(MAGIC); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05); send_byte(8'h05);
        idle(2);
        chk_status("midreset_recover", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("midreset_recover_nwr", 32'(wq.size()), 32'd1);

        // Randomized frames against a whole-frame model.
        for (int f = 0; f < 40; f++) begin
            wq.delete();
            fb.delete();
            exp_wr.delete();
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                b = 8'($urandom);
                if (b == MAGIC) b = 8'h3C;
                send_byte(b);
                idle(int'($urandom_range(0, 2)));
            end
            kind = int'($urandom_range(0, 9));
            fb.push_back(MAGIC);
            if (kind == 0) begin
                len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(129, 255));
                fb.push_back(len);
                exp_err = 1'b1;
            end else begin
                len = ($urandom_range(0, 4) == 0) ? 8'd128 : 8'($urandom_range(1, 12));
                fb.push_back(len);
                s = 8'd0;
                for (int w = 0; w < int'(len); w++) begin
                    hi = 8'($urandom);
                    lo = 8'($urandom);
                    fb.push_back(hi);
                    fb.push_back(lo);
                    exp_wr.push_back({8'(2 * w), hi, lo});
                    s = s + hi + lo;
                end
                exp_err = (kind <= 2);
                if (exp_err) s = s + 8'($urandom_range(1, 255));
                fb.push_back(s);
            end
            foreach (fb[i]) begin
                send_byte(fb[i]);
                idle(int'($urandom_range(0, 2)));
            end
            idle(2);
            chk_status($sformatf("rand%0d", f), exp_err, ~exp_err, ~exp_err, 1'b0);
            chk($sformatf("rand%0d_nwr", f), 32'(wq.size()), 32'(exp_wr.size()));
            for (int i = 0; i < exp_wr.size() && i < wq.size(); i++)
                chk($sformatf("rand%0d_wr%0d", f, i), 32'(wq[i]), 32'(exp_wr[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
